// File: rtl/ahb_decoder_if.sv
// ahb_decoder_if
// Groups the decoder's address-phase inputs and its select/default-slave
// outputs into one bundle.
//   master modport : drives haddr/htrans/hready, observes decode results
//   slave  modport : used by ahb_decoder itself
// Signals:
//   haddr[31:0]   address-phase address
//   htrans[1:0]   transfer type (bit 1 high = NONSEQ/SEQ)
//   hready        system hready fed back from the response mux
//   hsel_1..4     combinational one-hot region select
//   sel[1:0]      registered data-phase slave index for the mux
//   def_active    data phase belongs to the default slave
//   def_hreadyout default slave ready
//   def_hresp     default slave response (1 = ERROR)
interface ahb_decoder_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        hsel_1;
  logic        hsel_2;
  logic        hsel_3;
  logic        hsel_4;
  logic [1:0]  sel;
  logic        def_active;
  logic        def_hreadyout;
  logic        def_hresp;

  modport master (
    output haddr, htrans, hready,
    input  hsel_1, hsel_2, hsel_3, hsel_4, sel,
    input  def_active, def_hreadyout, def_hresp
  );

  modport slave (
    input  haddr, htrans, hready,
    output hsel_1, hsel_2, hsel_3, hsel_4, sel,
    output def_active, def_hreadyout, def_hresp
  );
endinterface

// File: rtl/ahb_decoder.sv
// ahb_decoder
// AHB-Lite address decoder for a four-slave response mux. Decodes haddr into
// a priority-resolved one-hot hsel, registers the winning index as the
// data-phase mux select, and (optionally) hosts a default slave that answers
// unmapped active transfers with a two-cycle ERROR response.
// Ports:
//   i_hclk    clock, rising edge
//   i_hresetn asynchronous active-low reset
//   io_bus    ahb_decoder_if.slave (see interface file for signal list)
// Parameters:
//   S1_BASE..S4_BASE region bases, S_MASK common region mask
// Configuration macro:
//   AHB_DEC_DEFSLV_EN  defined   -> default slave + ERROR FSM compiled in
//                      undefined -> unmapped addresses fall through to slave 4,
//                                   default-slave outputs tied inactive
module ahb_decoder #(
  parameter logic [31:0] S1_BASE = 32'h0000_0000,
  parameter logic [31:0] S2_BASE = 32'h1000_0000,
  parameter logic [31:0] S3_BASE = 32'h2000_0000,
  parameter logic [31:0] S4_BASE = 32'h3000_0000,
  parameter logic [31:0] S_MASK  = 32'hF000_0000
) (
  input logic           i_hclk,
  input logic           i_hresetn,
  ahb_decoder_if.slave  io_bus
);

  logic [3:0] w_match;
  logic [3:0] w_hsel;
  logic [1:0] w_idx;
  logic       w_hit;
  logic [1:0] r_sel;
  logic       w_unused;

  // htrans[0] (SEQ vs NONSEQ) never affects decoding.
  assign w_unused = ^io_bus.htrans;

  assign w_match[0] = (io_bus.haddr & S_MASK) == (S1_BASE & S_MASK);
  assign w_match[1] = (io_bus.haddr & S_MASK) == (S2_BASE & S_MASK);
  assign w_match[2] = (io_bus.haddr & S_MASK) == (S3_BASE & S_MASK);
  assign w_match[3] = (io_bus.haddr & S_MASK) == (S4_BASE & S_MASK);

  // Priority resolution: lowest-numbered slave wins when regions overlap, so
  // at most one hsel is ever high. Without the default slave, anything left
  // unmatched lands on slave 4.
  always_comb begin
    w_hsel = 4'b0000;
    w_idx  = 2'd0;
    w_hit  = 1'b0;
    if (w_match[0]) begin
      w_hsel = 4'b0001;
      w_idx  = 2'd0;
      w_hit  = 1'b1;
    end else if (w_match[1]) begin
      w_hsel = 4'b0010;
      w_idx  = 2'd1;
      w_hit  = 1'b1;
    end else if (w_match[2]) begin
      w_hsel = 4'b0100;
      w_idx  = 2'd2;
      w_hit  = 1'b1;
    end else begin
`ifdef AHB_DEC_DEFSLV_EN
      if (w_match[3]) begin
        w_hsel = 4'b1000;
        w_idx  = 2'd3;
        w_hit  = 1'b1;
      end
`else
      w_hsel = 4'b1000;
      w_idx  = 2'd3;
      w_hit  = 1'b1;
`endif
    end
  end

  assign io_bus.hsel_1 = w_hsel[0];
  assign io_bus.hsel_2 = w_hsel[1];
  assign io_bus.hsel_3 = w_hsel[2];
  assign io_bus.hsel_4 = w_hsel[3];
  assign io_bus.sel    = r_sel;

`ifdef AHB_DEC_DEFSLV_EN

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } defState_t;

  defState_t r_state;
  defState_t w_nextState;
  logic      r_defActive;
  logic      w_errReq;
  logic      w_hreadyout;
  logic      w_hresp;

  // An accepted address phase that is active but hits no region.
  assign w_errReq = io_bus.hready && io_bus.htrans[1] && !w_hit;

  // Address-phase capture. An unmapped phase keeps the previous sel so the
  // mux never glitches to an unrelated slave while the default slave answers.
  // An IDLE transfer accepted in the second ERROR cycle hands the data phase
  // back to the mux.
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_sel       <= 2'd0;
      r_defActive <= 1'b0;
    end else if (io_bus.hready) begin
      if (w_hit) begin
        r_sel       <= w_idx;
        r_defActive <= 1'b0;
      end else if ((r_state == ERR2) && !io_bus.htrans[1]) begin
        r_defActive <= 1'b0;
      end else begin
        r_defActive <= 1'b1;
      end
    end
  end

  // Default slave state register.
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // ERR1 advances unconditionally: it is the cycle that pulls system hready
  // low, so it cannot wait on hready itself. ERR2 chains straight into
  // another ERR1 for back-to-back unmapped transfers.
  always_comb begin
    w_nextState = r_state;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_errReq) w_nextState = ERR1;
      end
      ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
        w_nextState = ERR2;
      end
      ERR2: begin
        w_hresp = 1'b1;
        if (w_errReq) begin
          w_nextState = ERR1;
        end else if (io_bus.hready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign io_bus.def_active    = r_defActive;
  assign io_bus.def_hreadyout = w_hreadyout;
  assign io_bus.def_hresp     = w_hresp;

`else

  // Every address decodes somewhere, so capture is unconditional on hready.
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_sel <= 2'd0;
    end else if (io_bus.hready && w_hit) begin
      r_sel <= w_idx;
    end
  end

  assign io_bus.def_active    = 1'b0;
  assign io_bus.def_hreadyout = 1'b1;
  assign io_bus.def_hresp     = 1'b0;

`endif

endmodule

// File: tb/tb_ahb_decoder.sv
// tb_ahb_decoder
// Self-checking bench for ahb_decoder. A behavioural model (region table
// lookup plus an "ERROR cycles remaining" count) predicts every output; a
// negedge compare process checks the DUT against it each cycle, and directed
// sequences pin the model with literal expectations. Works with or without
// AHB_DEC_DEFSLV_EN defined.
module tb_ahb_decoder;

  localparam logic [31:0] S_MASK = 32'hF000_0000;
  localparam logic [31:0] BASES [4] = '{32'h0000_0000, 32'h1000_0000,
                                        32'h2000_0000, 32'h3000_0000};

  logic hclk;
  logic hresetn;
  int   assertCount;
  int   failCount;
  bit   cmpEn;

  // Model state: expected sel, def_active and position inside an ERROR
  // response (0 = none, 1 = first cycle, 2 = second cycle).
  int   mSel;
  bit   mDefActive;
  int   mErrPhase;

  ahb_decoder_if bus ();

  ahb_decoder dut (
    .i_hclk    (hclk),
    .i_hresetn (hresetn),
    .io_bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Region lookup: index of the first matching region, or -1 for a hole
  // (holes fall through to slave 4 when there is no default slave).
  function automatic int refDecode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & S_MASK) == (BASES[i] & S_MASK)) return i;
    end
`ifdef AHB_DEC_DEFSLV_EN
    return -1;
`else
    return 3;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mSel       = 0;
    mDefActive = 1'b0;
    mErrPhase  = 0;
  endtask

  // What the registers must hold after one rising edge with the current bus.
  task automatic modelEdge();
    int idx;
    idx = refDecode(bus.haddr);
    if (!hresetn) begin
      modelReset();
    end else if (mErrPhase == 1) begin
      mErrPhase = 2;
    end else if (bus.hready) begin
      if (idx >= 0) begin
        mSel       = idx;
        mDefActive = 1'b0;
      end else begin
        mDefActive = !((mErrPhase == 2) && !bus.htrans[1]);
      end
      mErrPhase = ((idx < 0) && bus.htrans[1]) ? 1 : 0;
    end
  endtask

  // Drive one address phase (called ~2 time units after a rising edge) and
  // advance through the next edge. hready is the system hready: the default
  // slave's ready while it owns the data phase, otherwise the mux's ready.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                               input bit rdyReq);
    bus.haddr  = addr;
    bus.htrans = trans;
    bus.hready = mDefActive ? (mErrPhase != 1) : rdyReq;
    @(posedge hclk);
    modelEdge();
    #2;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge hclk) begin
    if (cmpEn) begin
      int idx;
      logic [3:0] expSel;
      idx    = refDecode(bus.haddr);
      expSel = (idx >= 0) ? (4'b0001 << idx) : 4'b0000;
      checkOutput("hselVec", {bus.hsel_4, bus.hsel_3, bus.hsel_2, bus.hsel_1}, expSel);
      checkOutput("sel", bus.sel, mSel);
      checkOutput("defActive", bus.def_active, mDefActive);
      checkOutput("defHreadyout", bus.def_hreadyout, mErrPhase != 1);
      checkOutput("defHresp", bus.def_hresp, mErrPhase != 0);
    end
  end

  initial begin
    bit [3:0] nibs [7];
    nibs = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hF};
    assertCount = 0;
    failCount   = 0;
    cmpEn       = 1'b0;
    hresetn     = 1'b0;
    bus.haddr   = 32'h0;
    bus.htrans  = 2'b00;
    bus.hready  = 1'b1;
    modelReset();
    repeat (3) @(posedge hclk);
    #2;
    checkOutput("rstSel", bus.sel, 2'd0);
    checkOutput("rstDefActive", bus.def_active, 1'b0);
    checkOutput("rstHreadyout", bus.def_hreadyout, 1'b1);
    checkOutput("rstHresp", bus.def_hresp, 1'b0);
    hresetn = 1'b1;
    cmpEn   = 1'b1;

    // NONSEQ to slave 3, then hold hready low for three cycles.
    bus.haddr  = 32'h2000_0040;
    bus.htrans = 2'b10;
    #1;
    checkOutput("hsel3Comb", bus.hsel_3, 1'b1);
    checkOutput("hsel1Comb", bus.hsel_1, 1'b0);
    applyStimulus(32'h2000_0040, 2'b10, 1'b1);
    checkOutput("selSlave3", bus.sel, 2'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0000_0000, 2'b10, 1'b0);
      checkOutput("selHoldWait", bus.sel, 2'd2);
    end

    // Consecutive accesses: sel follows one cycle late.
    applyStimulus(32'h0000_0000, 2'b10, 1'b1);
    checkOutput("selSeq0", bus.sel, 2'd0);
    applyStimulus(32'h1000_0000, 2'b11, 1'b1);
    checkOutput("selSeq1", bus.sel, 2'd1);
    applyStimulus(32'h3000_0000, 2'b10, 1'b1);
    checkOutput("selSeq3", bus.sel, 2'd3);
    applyStimulus(32'h1000_0010, 2'b10, 1'b1);
    checkOutput("selSeq1b", bus.sel, 2'd1);

`ifdef AHB_DEC_DEFSLV_EN
    // Unmapped NONSEQ: ERR1, ERR2, then back to IDLE; sel keeps 1.
    applyStimulus(32'h8000_0000, 2'b10, 1'b1);
    checkOutput("errDefActive", bus.def_active, 1'b1);
    checkOutput("err1Ready", bus.def_hreadyout, 1'b0);
    checkOutput("err1Resp", bus.def_hresp, 1'b1);
    checkOutput("errSelHold", bus.sel, 2'd1);
    applyStimulus(32'h0000_0000, 2'b00, 1'b1);
    checkOutput("err2Ready", bus.def_hreadyout, 1'b1);
    checkOutput("err2Resp", bus.def_hresp, 1'b1);
    applyStimulus(32'h0000_0000, 2'b00, 1'b1);
    checkOutput("errDoneResp", bus.def_hresp, 1'b0);
    checkOutput("errDoneActive", bus.def_active, 1'b0);
    checkOutput("errDoneSel", bus.sel, 2'd0);
`else
    // Unmapped address falls through to slave 4 with no ERROR.
    bus.haddr  = 32'h8000_0000;
    bus.htrans = 2'b10;
    #1;
    checkOutput("hsel4Fallback", bus.hsel_4, 1'b1);
    applyStimulus(32'h8000_0000, 2'b10, 1'b1);
    checkOutput("selFallback", bus.sel, 2'd3);
    checkOutput("noDefResp", bus.def_hresp, 1'b0);
    checkOutput("noDefActive", bus.def_active, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus({nibs[$urandom_range(0, 6)], 28'($urandom)}, 2'($urandom),
                    $urandom_range(0, 9) < 7);
    end

`ifdef AHB_DEC_DEFSLV_EN
    // Back-to-back unmapped transfers, reset dropped in the second ERR1.
    applyStimulus(32'h1000_0000, 2'b10, 1'b1);
    applyStimulus(32'h0000_0000, 2'b00, 1'b1);
    applyStimulus(32'h9000_0000, 2'b10, 1'b1);
    checkOutput("b2bErr1aResp", bus.def_hresp, 1'b1);
    checkOutput("b2bErr1aReady", bus.def_hreadyout, 1'b0);
    applyStimulus(32'h9000_0000, 2'b10, 1'b1);
    checkOutput("b2bErr2aReady", bus.def_hreadyout, 1'b1);
    applyStimulus(32'h9000_0000, 2'b10, 1'b1);
    checkOutput("b2bErr1bReady", bus.def_hreadyout, 1'b0);
    checkOutput("b2bErr1bResp", bus.def_hresp, 1'b1);
`else
    applyStimulus(32'h2000_0000, 2'b10, 1'b1);
    checkOutput("preRstSel", bus.sel, 2'd2);
`endif
    hresetn = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncRstSel", bus.sel, 2'd0);
    checkOutput("asyncRstActive", bus.def_active, 1'b0);
    checkOutput("asyncRstReady", bus.def_hreadyout, 1'b1);
    checkOutput("asyncRstResp", bus.def_hresp, 1'b0);
    @(posedge hclk);
    #2;
    hresetn = 1'b1;
    applyStimulus(32'h3000_0000, 2'b10, 1'b1);
    checkOutput("postRstSel", bus.sel, 2'd3);
    @(negedge hclk);
    cmpEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
